// File: rtl/maxpool_2x2.sv
// -----------------------------------------------------------------------------
// maxpool_2x2
//   Streaming 2x2, stride-2 max-pool stage placed directly after relu.
//   Pixels arrive in raster order from a first-word-fall-through FIFO. One
//   signed maximum is emitted per non-overlapping 2x2 window, in raster order
//   of the pooled image. Image position is tracked with column/row counters,
//   so no frame markers are needed.
//
//   A line buffer of WIDTH/2 entries holds the horizontal pair maxima of each
//   even row. On the following odd row, each pair maximum is combined with the
//   line-buffer entry for the same window to form the window result.
//
// Ports
//   clock           in   1       single clock, rising edge
//   reset           in   1       synchronous, active-high
//   fifo_in_rd_en   out  1       pop request to input FIFO (combinational)
//   fifo_in_dout    in   DWIDTH  signed input pixel, valid when !fifo_in_empty
//   fifo_in_empty   in   1       input FIFO empty
//   fifo_out_wr_en  out  1       push to output FIFO (from registered state)
//   fifo_out_din    out  DWIDTH  signed pooled pixel (registered)
//   fifo_out_full   in   1       output FIFO full
// -----------------------------------------------------------------------------
module maxpool_2x2 #(
    parameter int DWIDTH = 8,
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     fifo_in_rd_en,
    input  logic signed [DWIDTH-1:0] fifo_in_dout,
    input  logic                     fifo_in_empty,
    output logic                     fifo_out_wr_en,
    output logic signed [DWIDTH-1:0] fifo_out_din,
    input  logic                     fifo_out_full
);

    localparam int HALF = WIDTH / 2;
    localparam int CW   = (WIDTH > 2)  ? $clog2(WIDTH)  : 1;
    localparam int RW   = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
    localparam int LW   = (HALF > 1)   ? $clog2(HALF)   : 1;

    logic [CW-1:0]             col;
    logic [RW-1:0]             row;
    logic                      pend;
    logic signed [DWIDTH-1:0]  hold;
    logic signed [DWIDTH-1:0]  lbuf [HALF];

    logic [LW-1:0]             lidx;
    logic signed [DWIDTH-1:0]  pair_max;
    logic signed [DWIDTH-1:0]  quad_max;
    logic                      last_col;
    logic                      last_row;

    // Signed maximum; no width change, so no saturation is ever needed.
    function automatic logic signed [DWIDTH-1:0] smax(
        input logic signed [DWIDTH-1:0] a,
        input logic signed [DWIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // A pending result that cannot be pushed stalls the input, so a fresh
    // result can never overwrite one that has not yet left.
    assign fifo_in_rd_en  = !reset && !fifo_in_empty && !(pend && fifo_out_full);
    assign fifo_out_wr_en = !reset && pend && !fifo_out_full;

    assign lidx     = LW'(col >> 1);
    assign pair_max = smax(hold, fifo_in_dout);
    assign quad_max = smax(lbuf[lidx], pair_max);
    assign last_col = (col == CW'(WIDTH - 1));
    assign last_row = (row == RW'(HEIGHT - 1));

    // ---- stage: position counters, pair hold, result register ----
    always_ff @(posedge clock) begin
        if (reset) begin
            col          <= '0;
            row          <= '0;
            pend         <= 1'b0;
            hold         <= '0;
            fifo_out_din <= '0;
        end else begin
            if (fifo_out_wr_en) begin
                pend <= 1'b0;
            end
            if (fifo_in_rd_en) begin
                if (!col[0]) begin
                    hold <= fifo_in_dout;
                end else if (row[0]) begin
                    // Bottom-right pixel of a window: a set here wins over
                    // the clear above, so a same-cycle push and new result
                    // keep the new result pending.
                    fifo_out_din <= quad_max;
                    pend         <= 1'b1;
                end
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // ---- stage: line buffer of even-row pair maxima ----
    // Never cleared: every entry is written on an even row before the odd
    // row reads it.
    always_ff @(posedge clock) begin
        if (fifo_in_rd_en && col[0] && !row[0]) begin
            lbuf[lidx] <= pair_max;
        end
    end

endmodule

// File: tb/tb_maxpool_2x2.sv
module tb_maxpool_2x2;

    localparam int DW   = 8;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int NOUT = (W / 2) * (H / 2);

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  fifo_in_rd_en;
    logic signed [DW-1:0]  fifo_in_dout = '0;
    logic                  fifo_in_empty = 1'b1;
    logic                  fifo_out_wr_en;
    logic signed [DW-1:0]  fifo_out_din;
    logic                  fifo_out_full = 1'b0;

    always #5 clock = ~clock;

    maxpool_2x2 #(.DWIDTH(DW), .WIDTH(W), .HEIGHT(H)) dut (
        .clock          (clock),
        .reset          (reset),
        .fifo_in_rd_en  (fifo_in_rd_en),
        .fifo_in_dout   (fifo_in_dout),
        .fifo_in_empty  (fifo_in_empty),
        .fifo_out_wr_en (fifo_out_wr_en),
        .fifo_out_din   (fifo_out_din),
        .fifo_out_full  (fifo_out_full)
    );

    typedef struct {
        int px [NPIX];
        int ex [NOUT];
    } vec_t;

    int errors = 0;
    int checks = 0;
    int src_q[$];
    int out_q[$];
    int exp_q[$];
    int pop_cyc[$];
    int wr_cyc[$];
    int cyc = 0;
    int run_start = 0;
    int rel_pops = -1;
    int proto_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle: inputs change after the falling edge, outputs are
    // sampled 1 ns later, well before the rising edge.
    task automatic step(input bit full, input bit gap);
        fifo_out_full = full;
        fifo_in_empty = gap || (src_q.size() == 0);
        fifo_in_dout  = (src_q.size() != 0) ? DW'(src_q[0]) : DW'($urandom);
        #1;
        if (fifo_out_wr_en && fifo_out_full) proto_bad++;
        if (fifo_in_rd_en && fifo_in_empty) proto_bad++;
        if (!reset && fifo_in_rd_en) begin
            void'(src_q.pop_front());
            pop_cyc.push_back(cyc);
        end
        if (!reset && fifo_out_wr_en) begin
            out_q.push_back(int'(fifo_out_din));
            wr_cyc.push_back(cyc);
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    // Feed everything in src_q and collect n_exp results under optional
    // forced-full window, random input gaps and random output full.
    task automatic run(input int n_exp, input int full_until, input int empty_pct,
                       input int full_pct, input string tag);
        int lc;
        bit f;
        bit g;
        lc = 0;
        out_q.delete();
        wr_cyc.delete();
        pop_cyc.delete();
        proto_bad = 0;
        rel_pops  = -1;
        run_start = cyc;
        while ((out_q.size() < n_exp || src_q.size() != 0) && lc < 2000) begin
            f = (lc <= full_until) || ($urandom_range(99) < full_pct);
            g = ($urandom_range(99) < empty_pct);
            step(f, g);
            if (lc == full_until) rel_pops = pop_cyc.size();
            lc++;
        end
        if (lc >= 2000) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d results, expected %0d", tag, out_q.size(), n_exp);
        end
        repeat (4) step(1'b0, 1'b0);
        check({tag, " count"}, out_q.size(), n_exp);
        check({tag, " protocol"}, proto_bad, 0);
    endtask

    // Reference: max of each 2x2 window of every complete frame, raster order.
    function automatic void pool_model(input int px[$]);
        int m;
        int v;
        exp_q.delete();
        for (int f = 0; f < px.size() / NPIX; f++)
            for (int r = 0; r < H / 2; r++)
                for (int c = 0; c < W / 2; c++) begin
                    m = -1000;
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++) begin
                            v = px[f * NPIX + (2 * r + dr) * W + 2 * c + dc];
                            if (v > m) m = v;
                        end
                    exp_q.push_back(m);
                end
    endfunction

    task automatic compare_out(input string tag);
        for (int k = 0; k < exp_q.size(); k++)
            check($sformatf("%s out[%0d]", tag, k),
                  (k < out_q.size()) ? out_q[k] : -9999, exp_q[k]);
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int v = lo; v <= hi; v++) src_q.push_back(v);
    endtask

    vec_t vecs [4];
    int   rpx[$];

    initial begin
        vecs[0] = '{'{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16},
                    '{6, 8, 14, 16}};
        vecs[1] = '{'{-5, -3, -7, -9, -8, -1, -2, -6, 0, 0, 0, 0, -128, 127, -1, -1},
                    '{-1, -2, 127, 0}};
        vecs[2] = '{'{1, -1, -1, 1, -1, -1, -1, -1, -2, -1, -128, -128, -3, -4, -128, -127},
                    '{1, 1, -1, -127}};
        vecs[3] = '{'{16, 15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1},
                    '{16, 14, 8, 6}};

        // Reset state with data available and output not full
        src_q.push_back(99);
        reset = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        fifo_in_empty = 1'b0;
        fifo_out_full = 1'b0;
        #1;
        check("reset rd_en", int'(fifo_in_rd_en), 0);
        check("reset wr_en", int'(fifo_out_wr_en), 0);
        check("reset dout", int'(fifo_out_din), 0);
        @(negedge clock);
        cyc++;
        src_q.delete();
        reset = 1'b0;

        // Table-driven single frames, no back-pressure
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < NPIX; i++) src_q.push_back(vecs[t].px[i]);
            run(NOUT, -1, 0, 0, $sformatf("vec%0d", t));
            for (int k = 0; k < NOUT; k++)
                check($sformatf("vec%0d out[%0d]", t, k),
                      (k < out_q.size()) ? out_q[k] : -9999, vecs[t].ex[k]);
            if (t == 0) begin
                // write follows the bottom-right pop by exactly one cycle
                for (int k = 0; k < NOUT; k++) begin
                    int br;
                    br = (2 * (k / 2) + 1) * W + 2 * (k % 2) + 1;
                    check($sformatf("latency[%0d]", k),
                          (k < wr_cyc.size() && br < pop_cyc.size()) ? wr_cyc[k] - pop_cyc[br] : -1, 1);
                end
            end
        end

        // Output full for the first 21 cycles: stall after pixel 6
        push_range(1, 16);
        run(NOUT, 20, 0, 0, "full0to20");
        check("full0to20 pops while stalled", rel_pops, 6);
        check("full0to20 first write cycle",
              (wr_cyc.size() > 0) ? wr_cyc[0] - run_start : -1, 21);
        exp_q = '{6, 8, 14, 16};
        compare_out("full0to20");

        // Random input gaps and random output full, fixed pixels
        push_range(1, 16);
        run(NOUT, -1, 50, 30, "gaps");
        compare_out("gaps");

        // Two frames back to back
        push_range(1, 32);
        run(2 * NOUT, -1, 0, 0, "twoframes");
        exp_q = '{6, 8, 14, 16, 22, 24, 30, 32};
        compare_out("twoframes");

        // Random pixels, random handshakes, against the reference model
        for (int it = 0; it < 4; it++) begin
            rpx.delete();
            for (int i = 0; i < 2 * NPIX; i++) rpx.push_back(int'($urandom_range(255)) - 128);
            pool_model(rpx);
            src_q = rpx;
            run(2 * NOUT, -1, 50, 30, $sformatf("rand%0d", it));
            compare_out($sformatf("rand%0d", it));
        end

        // Reset mid-frame with a result pending
        out_q.delete();
        pop_cyc.delete();
        push_range(1, 7);
        repeat (12) step(1'b1, 1'b0);
        check("abort pops before reset", pop_cyc.size(), 6);
        reset = 1'b1;
        step(1'b0, 1'b0);
        fifo_out_full = 1'b0;
        fifo_in_empty = 1'b0;
        #1;
        check("abort wr_en in reset", int'(fifo_out_wr_en), 0);
        check("abort rd_en in reset", int'(fifo_in_rd_en), 0);
        @(negedge clock);
        cyc++;
        check("abort no output", out_q.size(), 0);
        src_q.delete();
        reset = 1'b0;
        push_range(1, 16);
        run(NOUT, -1, 0, 0, "afterreset");
        exp_q = '{6, 8, 14, 16};
        compare_out("afterreset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
